// File: rtl/lane_mask_accum.sv
// lane_mask_accum: sums the masked lanes of each input beat and accumulates those sums over a
// frame. A frame is cfg_len+1 beats long, or shorter if in_last ends it early. The frame result
// is returned on a valid/ready output port, and output backpressure stalls the input.
//
// Optional build macro: LANE_MASK_ACCUM_SATURATE_EN
//   Defined:   a frame sum that overflows clamps to all-ones and reports out_ovf=1.
//   Undefined: the accumulator wraps modulo 2^AW and out_ovf is tied to 0.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cfg_len                       beats per frame minus 1, sampled on the first beat of a frame
//   in_valid/in_ready             input beat handshake
//   in_data, in_mask, in_last     CH lanes of DW bits, per-lane enable, early frame end
//   out_valid/out_ready           result handshake
//   out_sum, out_beats, out_ovf   frame sum, beats-1, overflow flag
module lane_mask_accum #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned AW    = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  input  logic [CH-1:0]    in_mask,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_sum,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam int unsigned SW = DW + $clog2(CH);

  localparam logic [0:0] StAcc  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, len_q;
  logic             s1_valid_q, s1_last_q;
  logic [SW-1:0]    s1_sum_q;
  logic [CNT_W-1:0] s1_cnt_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic             accept, s2_take, beat_is_last;
  logic [CNT_W-1:0] len_eff;
  logic [SW-1:0]    lane_sum;
  logic [AW-1:0]    acc_add;

  assign s2_take  = s1_valid_q && (state_q == StAcc);
  assign in_ready = !s1_valid_q || s2_take;
  assign accept   = in_valid && in_ready;

  // The frame length is taken live on beat 0 and from the held copy on every later beat.
  assign len_eff      = (beat_cnt_q == '0) ? cfg_len : len_q;
  assign beat_is_last = in_last || (beat_cnt_q == len_eff);

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < CH; i++) begin
      if (in_mask[i]) lane_sum = lane_sum + SW'(in_data[i*DW +: DW]);
    end
  end

`ifdef LANE_MASK_ACCUM_SATURATE_EN
  logic [AW:0] add_full;
  logic        add_ovf;
  logic        ovf_flag_q, ovf_flag_d;
  logic        out_ovf_q, out_ovf_d;

  assign add_full = {1'b0, acc_q} + {{(AW + 1 - SW){1'b0}}, s1_sum_q};
  assign add_ovf  = add_full[AW];
  assign acc_add  = add_ovf ? '1 : add_full[AW-1:0];
  assign out_ovf  = out_ovf_q;
`else
  assign acc_add = acc_q + AW'(s1_sum_q);
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
`ifdef LANE_MASK_ACCUM_SATURATE_EN
    ovf_flag_d  = ovf_flag_q;
    out_ovf_d   = out_ovf_q;
`endif
    case (state_q)
      StAcc: begin
        if (s2_take) begin
          if (s1_last_q) begin
            out_sum_d   = acc_add;
            out_beats_d = s1_cnt_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            state_d     = StHold;
`ifdef LANE_MASK_ACCUM_SATURATE_EN
            out_ovf_d   = ovf_flag_q | add_ovf;
            ovf_flag_d  = 1'b0;
`endif
          end else begin
            acc_d = acc_add;
`ifdef LANE_MASK_ACCUM_SATURATE_EN
            ovf_flag_d = ovf_flag_q | add_ovf;
`endif
          end
        end
      end
      StHold: begin
        // S1 is deliberately not drained in this cycle, giving one bubble after release.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StAcc;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      s1_cnt_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
`ifdef LANE_MASK_ACCUM_SATURATE_EN
      ovf_flag_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (beat_cnt_q == '0) len_q <= cfg_len;
        beat_cnt_q <= beat_is_last ? '0 : beat_cnt_q + CNT_W'(1);
        s1_valid_q <= 1'b1;
        s1_sum_q   <= lane_sum;
        s1_cnt_q   <= beat_cnt_q;
        s1_last_q  <= beat_is_last;
      end else if (s2_take) begin
        s1_valid_q <= 1'b0;
      end
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
`ifdef LANE_MASK_ACCUM_SATURATE_EN
      ovf_flag_q  <= ovf_flag_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;

endmodule

// File: tb/tb_lane_mask_accum.sv
// Directed testbench for lane_mask_accum (CH=4, DW=16, AW=24, CNT_W=8).
module tb_lane_mask_accum;
  localparam int DW    = 16;
  localparam int CH    = 4;
  localparam int AW    = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CH*DW-1:0] in_data = '0;
  logic [CH-1:0]    in_mask = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW-1:0]    out_sum;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] sb_sum[$];

  lane_mask_accum #(.DW(DW), .CH(CH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_beats(out_beats),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) sb_sum.push_back(out_sum);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [CH*DW-1:0] lanes(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [CH*DW-1:0] d, input logic [CH-1:0] m, input logic l);
    int n = 0;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 want 1 within 100 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for out_valid (bounded); with out_ready=1 the result is consumed before return.
  task automatic wait_out(output bit found, output logic [AW-1:0] s,
                          output logic [CNT_W-1:0] b, output logic o);
    found = 1'b0;
    s = '0;
    b = '0;
    o = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (out_valid) begin
        found = 1'b1;
        s = out_sum;
        b = out_beats;
        o = out_ovf;
        break;
      end
      @(negedge clk);
    end
    if (found) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_sum, out_beats, out_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b sum=%0d beats=%0d ovf=%0b want all 0",
               out_valid, out_sum, out_beats, out_ovf);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_basic_frame();
    cfg_len   = 8'd2;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(lanes(1, 2, 3, 4), 4'hF, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: got %0b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd30 || out_beats !== 8'd2) begin
      failures++;
      $display("FAIL basic_result: got v=%0b sum=%0d beats=%0d want v=1 sum=30 beats=2",
               out_valid, out_sum, out_beats);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_width: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_mask_single_beat();
    bit f;
    logic [AW-1:0] s;
    logic [CNT_W-1:0] b;
    logic o;
    cfg_len = 8'd0;
    send(lanes(10, 20, 30, 40), 4'b0101, 1'b0);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd40 || b !== 8'd0) begin
      failures++;
      $display("FAIL mask_0101: got found=%0b sum=%0d beats=%0d want 1/40/0", f, s, b);
    end
    send(lanes(10, 20, 30, 40), 4'h0, 1'b0);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd0 || b !== 8'd0) begin
      failures++;
      $display("FAIL mask_zero: got found=%0b sum=%0d beats=%0d want 1/0/0", f, s, b);
    end
  endtask

  task automatic test_in_last_and_len();
    bit f;
    logic [AW-1:0] s;
    logic [CNT_W-1:0] b;
    logic o;
    cfg_len = 8'd7;
    send(lanes(1, 0, 0, 0), 4'hF, 1'b0);
    send(lanes(2, 0, 0, 0), 4'hF, 1'b1);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd3 || b !== 8'd1) begin
      failures++;
      $display("FAIL last_beat1: got found=%0b sum=%0d beats=%0d want 1/3/1", f, s, b);
    end
    send(lanes(1, 1, 1, 1), 4'hF, 1'b0);
    send(lanes(1, 1, 1, 1), 4'hF, 1'b0);
    send(lanes(1, 1, 1, 1), 4'hF, 1'b1);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd12 || b !== 8'd2) begin
      failures++;
      $display("FAIL last_beat2: got found=%0b sum=%0d beats=%0d want 1/12/2", f, s, b);
    end
    // cfg_len change after beat 0 must not shorten the frame.
    send(lanes(1, 1, 1, 1), 4'hF, 1'b0);
    cfg_len = 8'd1;
    for (int i = 0; i < 7; i++) send(lanes(1, 1, 1, 1), 4'hF, 1'b0);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd32 || b !== 8'd7) begin
      failures++;
      $display("FAIL len_mid_change: got found=%0b sum=%0d beats=%0d want 1/32/7", f, s, b);
    end
  endtask

  task automatic test_back_to_back();
    bit f;
    logic [AW-1:0] s;
    logic [CNT_W-1:0] b;
    logic o;
    bit seen;
    bit dropped;
    sb_sum.delete();
    cfg_len   = 8'd1;
    out_ready = 1'b0;
    fork
      begin
        send(lanes(1, 2, 3, 4), 4'hF, 1'b0);
        send(lanes(5, 6, 7, 8), 4'hF, 1'b0);
        send(lanes(100, 0, 0, 0), 4'h1, 1'b0);
        send(lanes(0, 200, 0, 0), 4'hF, 1'b0);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = out_valid;
        end
        checks++;
        if (!seen) begin
          failures++;
          $display("FAIL bp_first_valid: got 0 want 1 within 50 cycles");
        end
        dropped = 1'b0;
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (out_valid !== 1'b1 || out_sum !== 24'd36 || out_beats !== 8'd1) begin
            failures++;
            $display("FAIL bp_hold_stable: got v=%0b sum=%0d beats=%0d want 1/36/1",
                     out_valid, out_sum, out_beats);
          end
          if (!in_ready) dropped = 1'b1;
          @(negedge clk);
        end
        checks++;
        if (dropped !== 1'b1) begin
          failures++;
          $display("FAIL bp_in_ready_drop: got %0b want 1", dropped);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL bp_release: got out_valid=%0b want 0", out_valid);
        end
      end
    join
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd300 || b !== 8'd1) begin
      failures++;
      $display("FAIL bp_second_frame: got found=%0b sum=%0d beats=%0d want 1/300/1", f, s, b);
    end
    checks++;
    if (sb_sum.size() != 2 || sb_sum[0] !== 24'd36 || sb_sum[1] !== 24'd300) begin
      failures++;
      $display("FAIL bp_scoreboard: got %0d results want 2 (36,300)", sb_sum.size());
    end
  endtask

  task automatic test_overflow();
    bit f;
    logic [AW-1:0] s;
    logic [CNT_W-1:0] b;
    logic o;
    logic [AW-1:0] exp_sum;
    logic exp_ovf;
`ifdef LANE_MASK_ACCUM_SATURATE_EN
    exp_sum = 24'hFFFFFF;
    exp_ovf = 1'b1;
`else
    exp_sum = 24'd16776192;
    exp_ovf = 1'b0;
`endif
    cfg_len   = 8'd255;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'hF, 1'b0);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== exp_sum || b !== 8'd255 || o !== exp_ovf) begin
      failures++;
      $display("FAIL ovf_frame: got found=%0b sum=%0d beats=%0d ovf=%0b want sum=%0d beats=255 ovf=%0b",
               f, s, b, o, exp_sum, exp_ovf);
    end
    send(lanes(1, 0, 0, 0), 4'hF, 1'b1);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd1 || b !== 8'd0 || o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_next_frame: got found=%0b sum=%0d beats=%0d ovf=%0b want 1/1/0/0",
               f, s, b, o);
    end
  endtask

  task automatic test_async_reset();
    bit f;
    bit seen;
    logic [AW-1:0] s;
    logic [CNT_W-1:0] b;
    logic o;
    cfg_len   = 8'd0;
    out_ready = 1'b0;
    send(lanes(7, 0, 0, 0), 4'hF, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || out_sum !== 24'd7) begin
      failures++;
      $display("FAIL rst_pre_result: got v=%0b sum=%0d want 1/7", out_valid, out_sum);
    end
    cfg_len = 8'd3;
    send(lanes(9, 9, 9, 9), 4'hF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 24'd0 || out_beats !== 8'd0) begin
      failures++;
      $display("FAIL rst_async: got v=%0b sum=%0d beats=%0d want 0/0/0",
               out_valid, out_sum, out_beats);
    end
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    cfg_len   = 8'd0;
    send(lanes(5, 0, 0, 0), 4'hF, 1'b0);
    wait_out(f, s, b, o);
    checks++;
    if (!f || s !== 24'd5 || b !== 8'd0) begin
      failures++;
      $display("FAIL rst_fresh_frame: got found=%0b sum=%0d beats=%0d want 1/5/0", f, s, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mask_single_beat();
    test_in_last_and_len();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_mask_accum.md
Name: lane_mask_accum

Overview:
- Parametrised successor to the single-lane "sum when enabled" register path.
- Accepts beats of CH lanes with a per-beat lane mask, and sums the enabled lanes.
- Accumulates those sums over a frame of configurable length, then returns the frame result on a valid/ready output.
- Sits between lane producers and downstream consumers, and carries backpressure from the output back to the input.

Parameters:
- DW, 16, lane data width (unsigned).
- CH, 4, lane count, ≥1.
- AW, 24, accumulator/result width, ≥ DW+$clog2(CH).
- CNT_W, 8, frame-length counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cfg_len  in  CNT_W  beats per frame minus 1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_data  in  CH*DW  lane i at [i*DW +: DW].
- in_mask  in  CH  lane i contributes iff in_mask[i].
- in_last  in  1  force frame end on this beat.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- out_sum  out  AW  frame sum.
- out_beats  out  CNT_W  beats in frame minus 1.
- out_ovf  out  1  frame overflowed (SATURATE_EN only).

Behaviour:
- Reset (rst low, async): state=ACC, s1_valid=0, acc=0, beat_cnt=0, out_valid=0, out_sum=0, out_beats=0, out_ovf=0. in_ready=1 from the first clock after release. Reset mid-frame discards all partial data.
- Stage S1 (registered), on each accept:
  - s1_sum = zero-extended sum of masked lanes, width DW+$clog2(CH).
  - s1_cnt = beat_cnt.
  - s1_last = in_last || beat_cnt==len. len is cfg_len sampled at the frame's first beat (beat_cnt==0) and held for the frame; cfg_len changes mid-frame are ignored.
  - beat_cnt increments, and clears to 0 after the last beat.
- S2 take: s2_take = s1_valid && state==ACC. in_ready = !s1_valid || s2_take.
- FSM ACC, on s2_take:
  - Not last: acc <= acc+s1_sum.
  - Last: out_sum <= acc+s1_sum, out_beats <= s1_cnt, out_valid <= 1, acc <= 0, state -> HOLD.
- FSM HOLD:
  - out_sum, out_beats, out_ovf stable; S1 holds.
  - On out_ready: out_valid <= 0, state -> ACC.
  - S1 is not taken in the same cycle, so there is exactly one bubble.
- Latency: last beat accepted at cycle T -> out_valid high at T+2 (state ACC at T+1).
- Arithmetic: all unsigned. Without SATURATE_EN, acc wraps modulo 2^AW.
- cfg_len=0: every beat is a one-beat frame.
- in_last on beat 0: one-beat frame, out_beats=0.
- in_mask=0: contributes 0 but still counts as a beat.
- Back-to-back frames: beat 0 of the next frame may enter S1 while the prior result is in HOLD.
- No beat is dropped or duplicated under any in_valid/out_ready pattern. in_ready never depends combinationally on in_valid.

Optional Feature:
- Macro: LANE_MASK_ACCUM_SATURATE_EN.
- Defined:
  - An add whose true result exceeds 2^AW-1 clamps acc to all-ones and sets a sticky frame overflow flag.
  - out_ovf <= flag at frame end; the flag clears with acc.
- Undefined: acc wraps, out_ovf is tied 0, and the port remains present.

Test Plan (CH=4, DW=16, AW=24, CNT_W=8):
- cfg_len=2; three beats, lanes [1,2,3,4], mask 4'hF; out_ready=1 -> out_sum=30, out_beats=2, out_valid 2 cycles after third accept, high 1 cycle.
- cfg_len=0; lanes [10,20,30,40], mask 4'b0101 -> out_sum=40, out_beats=0; mask 4'h0 next beat -> out_sum=0.
- cfg_len=7; in_last on 2nd beat -> out_beats=1. Next frame of 3 beats + in_last -> out_beats=2; counter restarts at 0. Change cfg_len mid-frame -> ignored.
- out_ready=0 for 5 cycles with in_valid held high:
  - Result stays stable.
  - in_ready drops once S1 is full.
  - After release, the bubble occurs, then the second frame's sum is exact; scoreboard shows no lost or duplicated beat.
- Lanes all 16'hFFFF, mask 4'hF, cfg_len=255:
  - Without macro: out_sum=24'd16776192, out_ovf=0.
  - With macro: out_sum=24'hFFFFFF, out_ovf=1; next frame out_ovf=0.
- rst low asynchronously mid-frame (between clk edges):
  - out_valid=0 and out_sum=0 immediately.
  - After release, a fresh 1-beat frame [5,0,0,0] -> out_sum=5.
